// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219-style serial receiver: frame geometry,
// register address map and receiver FSM states.
// No ports; imported by max7219_sync_edge and max7219_serial_rx.
package max7219_pkg;

    // One MAX7219 frame is 16 bits: [15:12] don't care, [11:8] address, [7:0] data.
    localparam int FRAME_W = 16;
    localparam int CNT_W   = 5;

    // Register address map (frame bits 11:8).
    localparam logic [3:0] ADDR_NOOP         = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0       = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1       = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2       = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3       = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4       = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5       = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6       = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7       = 4'h8;
    localparam logic [3:0] ADDR_DECODE_MODE  = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY    = 4'hA;
    localparam logic [3:0] ADDR_SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN     = 4'hC;
    localparam logic [3:0] ADDR_RSVD_D       = 4'hD;
    localparam logic [3:0] ADDR_RSVD_E       = 4'hE;
    localparam logic [3:0] ADDR_DISPLAY_TEST = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // LOAD high, waiting for a frame to start
        ST_SHIFT = 2'd1,   // LOAD low, shifting serial bits in
        ST_LATCH = 2'd2    // single cycle: commit or reject the frame
    } state_e;

endpackage

// File: rtl/max7219_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input, with single-cycle
// rise/fall pulses detected on the synchronised level.
// Ports: clk, rst (sync, active-high), d_i (async in), q_o (synced level),
//        rise_o / fall_o (one-cycle edge pulses).
module max7219_sync_edge #(
    parameter int   G_STAGES  = 2,
    parameter logic G_RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [G_STAGES-1:0] sync_q;
    logic                prev_q;

    // The edge-detect flop resets to the same level as the chain so that
    // leaving reset never fabricates an edge when the pin is at its idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {G_STAGES{G_RST_VAL}};
            prev_q <= G_RST_VAL;
        end else begin
            sync_q <= {sync_q[G_STAGES-2:0], d_i};
            prev_q <= sync_q[G_STAGES-1];
        end
    end

    assign q_o    = sync_q[G_STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/max7219_serial_rx.sv
// Receiver for the MAX7219 3-wire serial protocol: shifts frames in, latches
// them into the digit/control register file on LOAD rising, and replays the
// shifted-out bits on a daisy-chain output.
// Ports: clk/rst; serial i_max7219_clk/din/load; o_max7219_dout; frame event
//        outputs o_frame_valid/err/addr/data; digit read port i_rd_addr ->
//        o_rd_data (1 cycle); control register mirrors.
module max7219_serial_rx
    import max7219_pkg::*;
#(
    parameter int G_SYNC_STAGES = 2,
    parameter int G_CHAIN_DOUT  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_max7219_clk,
    input  logic       i_max7219_din,
    input  logic       i_max7219_load,
    output logic       o_max7219_dout,
    output logic       o_frame_valid,
    output logic [3:0] o_frame_addr,
    output logic [7:0] o_frame_data,
    output logic       o_frame_err,
    input  logic [2:0] i_rd_addr,
    output logic [7:0] o_rd_data,
    output logic [7:0] o_decode_mode,
    output logic [3:0] o_intensity,
    output logic [2:0] o_scan_limit,
    output logic       o_shutdown_n,
    output logic       o_display_test
);

    // ---------------- input synchronisers ----------------
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic din_s, din_rise, din_fall;
    logic load_lvl, load_rise, load_fall;

    max7219_sync_edge #(.G_STAGES(G_SYNC_STAGES), .G_RST_VAL(1'b0)) u_sync_clk (
        .clk(clk), .rst(rst), .d_i(i_max7219_clk),
        .q_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    max7219_sync_edge #(.G_STAGES(G_SYNC_STAGES), .G_RST_VAL(1'b0)) u_sync_din (
        .clk(clk), .rst(rst), .d_i(i_max7219_din),
        .q_o(din_s), .rise_o(din_rise), .fall_o(din_fall)
    );

    max7219_sync_edge #(.G_STAGES(G_SYNC_STAGES), .G_RST_VAL(1'b1)) u_sync_load (
        .clk(clk), .rst(rst), .d_i(i_max7219_load),
        .q_o(load_lvl), .rise_o(load_rise), .fall_o(load_fall)
    );

    // Edge outputs of the data line and the plain levels of clock/load are
    // not needed by this block.
    logic sync_unused;
    assign sync_unused = ^{sclk_lvl, din_rise, din_fall, load_lvl};

    // ---------------- FSM ----------------
    state_e state_q, state_d;
    logic   cnt_clr, shift_en, dout_en, latch_ok, latch_err;

    logic [FRAME_W-1:0] shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               frame_full;

    assign frame_full = (cnt_q == CNT_W'(FRAME_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A LOAD rise and a serial clock rise in the same SHIFT cycle both act:
    // the shift happens on the same edge that moves into LATCH, so LATCH
    // already sees the final bit and count.
    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        dout_en   = 1'b0;
        latch_ok  = 1'b0;
        latch_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_fall) begin
                    state_d = ST_SHIFT;
                    cnt_clr = 1'b1;
                end
            end
            ST_SHIFT: begin
                shift_en = sclk_rise;
                dout_en  = sclk_fall;
                if (load_rise) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                latch_ok  = frame_full;
                latch_err = ~frame_full;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath / register file ----------------
    logic       dout_q;
    logic       valid_q, err_q;
    logic [3:0] addr_q;
    logic [7:0] data_q;
    logic [7:0] digit_q [8];
    logic [7:0] decode_q;
    logic [3:0] intensity_q;
    logic [2:0] scan_q;
    logic       shutdown_n_q;
    logic       dtest_q;
    logic [7:0] rd_data_q;

    logic [3:0] frame_addr;
    logic [7:0] frame_data;
    logic [2:0] digit_idx;

    assign frame_addr = shift_q[11:8];
    assign frame_data = shift_q[7:0];
    // Addresses 1..8 map onto digit 0..7; the 3-bit wrap turns 8 into 7.
    assign digit_idx  = shift_q[10:8] - 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q      <= '0;
            cnt_q        <= '0;
            dout_q       <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            for (int i = 0; i < 8; i++) begin
                digit_q[i] <= '0;
            end
            decode_q     <= '0;
            intensity_q  <= '0;
            scan_q       <= '0;
            shutdown_n_q <= 1'b0;
            dtest_q      <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= digit_q[i_rd_addr];

            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (shift_en && !frame_full) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (shift_en) begin
                shift_q <= {shift_q[FRAME_W-2:0], din_s};
            end

            // Bit 15 leaves the register on the falling serial edge, as the
            // downstream device samples it on the next rising edge.
            if (dout_en) begin
                dout_q <= (G_CHAIN_DOUT != 0) ? shift_q[FRAME_W-1] : 1'b0;
            end

            if (latch_ok) begin
                valid_q <= 1'b1;
                addr_q  <= frame_addr;
                data_q  <= frame_data;
                case (frame_addr)
                    ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
                    ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                        digit_q[digit_idx] <= frame_data;
                    ADDR_DECODE_MODE:  decode_q     <= frame_data;
                    ADDR_INTENSITY:    intensity_q  <= frame_data[3:0];
                    ADDR_SCAN_LIMIT:   scan_q       <= frame_data[2:0];
                    ADDR_SHUTDOWN:     shutdown_n_q <= frame_data[0];
                    ADDR_DISPLAY_TEST: dtest_q      <= frame_data[0];
                    ADDR_NOOP, ADDR_RSVD_D, ADDR_RSVD_E: ;
                    default: ;
                endcase
            end

            if (latch_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_max7219_dout = dout_q;
    assign o_frame_valid  = valid_q;
    assign o_frame_err    = err_q;
    assign o_frame_addr   = addr_q;
    assign o_frame_data   = data_q;
    assign o_rd_data      = rd_data_q;
    assign o_decode_mode  = decode_q;
    assign o_intensity    = intensity_q;
    assign o_scan_limit   = scan_q;
    assign o_shutdown_n   = shutdown_n_q;
    assign o_display_test = dtest_q;

endmodule

// File: tb/tb_max7219_serial_rx.sv
// Self-checking bench for max7219_serial_rx: directed protocol scenarios
// followed by randomized frames, compared against a bit-history model.
// Ports: none (top-level bench).
module tb_max7219_serial_rx;

    localparam int N = 2;   // synchroniser depth used for the DUT

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sclk, din, load;
    logic [2:0] rd_addr;
    logic       o_max7219_dout, o_frame_valid, o_frame_err;
    logic [3:0] o_frame_addr;
    logic [7:0] o_frame_data, o_rd_data, o_decode_mode;
    logic [3:0] o_intensity;
    logic [2:0] o_scan_limit;
    logic       o_shutdown_n, o_display_test;

    max7219_serial_rx #(.G_SYNC_STAGES(N), .G_CHAIN_DOUT(1)) dut (
        .clk(clk), .rst(rst),
        .i_max7219_clk(sclk), .i_max7219_din(din), .i_max7219_load(load),
        .o_max7219_dout(o_max7219_dout),
        .o_frame_valid(o_frame_valid), .o_frame_addr(o_frame_addr),
        .o_frame_data(o_frame_data), .o_frame_err(o_frame_err),
        .i_rd_addr(rd_addr), .o_rd_data(o_rd_data),
        .o_decode_mode(o_decode_mode), .o_intensity(o_intensity),
        .o_scan_limit(o_scan_limit), .o_shutdown_n(o_shutdown_n),
        .o_display_test(o_display_test)
    );

    int n_vec = 0;
    int n_err = 0;

    // Pulse counters observed on the DUT outputs (one count per high cycle).
    int n_valid_seen = 0;
    int n_ferr_seen  = 0;
    always @(negedge clk) begin
        if (o_frame_valid === 1'b1) n_valid_seen++;
        if (o_frame_err === 1'b1)   n_ferr_seen++;
    end

    // ---------------- reference model ----------------
    bit         hist[$];        // most recent serial bits since reset, oldest first (max 16)
    logic [7:0] m_digit[8];
    logic [7:0] m_decode;
    logic [3:0] m_int;
    logic [2:0] m_scan;
    logic       m_shut, m_dtest, m_dout;
    logic [3:0] m_addr;
    logic [7:0] m_data;
    int         m_valid, m_ferr;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
        m_decode = 8'h00; m_int = 4'h0; m_scan = 3'h0;
        m_shut = 1'b0; m_dtest = 1'b0; m_dout = 1'b0;
        m_addr = 4'h0; m_data = 8'h00;
    endtask

    task automatic model_apply(input logic [15:0] fr);
        int a;
        a = int'(fr[11:8]);
        if (a >= 1 && a <= 8) m_digit[a-1] = fr[7:0];
        else if (a == 9)      m_decode = fr[7:0];
        else if (a == 10)     m_int    = fr[3:0];
        else if (a == 11)     m_scan   = fr[2:0];
        else if (a == 12)     m_shut   = fr[0];
        else if (a == 15)     m_dtest  = fr[0];
    endtask

    // Drive-side helper: advance n rising edges and step just past the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        @(negedge clk);
        check_eq({tag, "_valid_cnt"}, n_valid_seen, m_valid);
        check_eq({tag, "_err_cnt"},   n_ferr_seen,  m_ferr);
        check_eq({tag, "_addr"},      o_frame_addr, m_addr);
        check_eq({tag, "_data"},      o_frame_data, m_data);
        check_eq({tag, "_decode"},    o_decode_mode, m_decode);
        check_eq({tag, "_intensity"}, o_intensity,  m_int);
        check_eq({tag, "_scan"},      o_scan_limit, m_scan);
        check_eq({tag, "_shutdown"},  o_shutdown_n, m_shut);
        check_eq({tag, "_dtest"},     o_display_test, m_dtest);
        @(posedge clk); #1;
    endtask

    task automatic check_digit(input string tag, input int idx);
        rd_addr = 3'(idx);
        @(posedge clk);
        @(negedge clk);
        check_eq(tag, o_rd_data, m_digit[idx]);
        @(posedge clk); #1;
    endtask

    // Send the low nbits of word MSB first. coincide: the final serial rising
    // edge and LOAD rising are driven together. do_load=0 leaves LOAD low.
    task automatic send_frame(input logic [63:0] word, input int nbits, input int half,
                              input bit coincide, input bit do_load, input string tag);
        logic [15:0] fr;
        bit          seen, joint;
        int          lat;
        load = 1'b0;
        cyc(half);
        joint = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) begin
            din = word[i];
            cyc(half);
            sclk = 1'b1;
            hist.push_back(word[i]);
            if (hist.size() > 16) void'(hist.pop_front());
            if (i == 0 && coincide && do_load) begin
                load  = 1'b1;
                joint = 1'b1;
            end else begin
                cyc(half);
                m_dout = (hist.size() == 16) ? hist[0] : 1'b0;
                sclk = 1'b0;
                cyc(half);
                @(negedge clk);
                check_eq({tag, "_dout"}, o_max7219_dout, m_dout);
                @(posedge clk); #1;
            end
        end
        if (!do_load) return;
        if (!joint) load = 1'b1;

        if (nbits >= 16) begin
            fr = 16'h0;
            for (int k = 0; k < 16; k++) fr = fr * 2 + 16'(hist[k]);
            m_addr = fr[11:8];
            m_data = fr[7:0];
            model_apply(fr);
            m_valid++;
        end else begin
            m_ferr++;
        end

        // Latency from the LOAD pin rising to the frame result pulse.
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_frame_valid === 1'b1 || o_frame_err === 1'b1) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check_eq({tag, "_latency"}, lat, N + 2);
        @(posedge clk); #1;
        if (joint) sclk = 1'b0;
        cyc(half + 2);
        check_regs(tag);
    endtask

    initial begin
        logic [63:0] w;
        int          nb, sel, hp;
        bit          co;

        rst = 1'b1; load = 1'b1; sclk = 1'b0; din = 1'b0; rd_addr = 3'd0;
        model_reset();
        m_valid = 0; m_ferr = 0;
        cyc(4);
        rst = 1'b0;
        cyc(2);

        // Reset state
        check_regs("reset");
        @(negedge clk);
        check_eq("reset_dout", o_max7219_dout, 1'b0);
        check_eq("reset_rd",   o_rd_data, 8'h00);
        @(posedge clk); #1;

        // Intensity frame
        send_frame(64'h0A07, 16, 4, 1'b0, 1'b1, "intensity");
        @(negedge clk);
        check_eq("intensity_is_7", o_intensity, 4'h7);
        @(posedge clk); #1;

        // Digit 2 write then read back through the registered port
        send_frame(64'h03A5, 16, 4, 1'b0, 1'b1, "digit2");
        check_digit("digit2_rd", 2);
        @(negedge clk);
        check_eq("digit2_rd_val", o_rd_data, 8'hA5);
        @(posedge clk); #1;

        // Short frame: 12 bits only
        send_frame(64'h0C01, 12, 4, 1'b0, 1'b1, "short12");

        // 32-bit daisy chain: only the last 16 bits latch
        send_frame(64'h0C01_0F01, 32, 4, 1'b0, 1'b1, "daisy");
        @(negedge clk);
        check_eq("daisy_dtest", o_display_test, 1'b1);
        check_eq("daisy_shutdown", o_shutdown_n, 1'b0);
        @(posedge clk); #1;

        // Reset in the middle of a shutdown frame
        send_frame(64'h0C, 8, 4, 1'b0, 1'b0, "partial");
        rst = 1'b1; load = 1'b1; sclk = 1'b0; din = 1'b0;
        cyc(5);
        model_reset();
        rst = 1'b0;
        cyc(3);
        check_regs("after_rst");
        send_frame(64'h0C01, 16, 4, 1'b0, 1'b1, "shutdown");
        @(negedge clk);
        check_eq("shutdown_set", o_shutdown_n, 1'b1);
        @(posedge clk); #1;

        // LOAD rising together with the 16th serial clock rising edge
        send_frame(64'h0105, 16, 4, 1'b1, 1'b1, "coincide");
        check_digit("coincide_digit0", 0);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            w   = {$urandom, $urandom};
            sel = $urandom_range(0, 3);
            case (sel)
                0:       nb = 16;
                1:       nb = 32;
                2:       nb = $urandom_range(1, 15);
                default: nb = $urandom_range(17, 30);
            endcase
            hp = $urandom_range(4, 6);
            co = 1'($urandom_range(0, 1));
            send_frame(w, nb, hp, co, 1'b1, "rand");
        end
        for (int d = 0; d < 8; d++) check_digit("final_digit", d);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
